qed_inst_stream_constraint: RTL and testbench

//  Sequential constraint generator for SQED formal runs on RV32I cores. It sits between the

---
 rtl/qed_constraint_pkg.sv | 60 ++++++
 rtl/qed_inst_decode.sv | 110 +++++++++++
 rtl/qed_inst_stream_constraint.sv | 154 +++++++++++++++
 tb/tb_qed_inst_stream_constraint.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qed_constraint_pkg.sv
// Shared encodings and types for the SQED instruction-stream constraint.
package qed_constraint_pkg;

  // RV32I major opcodes, plus the custom NOP opcode used while draining
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_NOP    = 7'b1111111;

  // funct3 values that carry extra funct7 rules
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_FENCE   = 3'b000;
  localparam logic [2:0] F3_JALR    = 3'b000;

  // funct7 values: base ops and the SUB/SRA/SRAI alternate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // The only SYSTEM words allowed through
  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } qed_phase_e;

  // One-hot instruction class; all-zero means an unrecognised opcode
  typedef struct packed {
    logic r;
    logic i;
    logic ld;
    logic st;
    logic b;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic fence;
    logic sys;
    logic nop;
  } inst_class_t;

  // Register index is inside the window reserved for original instructions
  function automatic logic reg_ok(input logic [4:0] r, input int lim);
    return ({27'd0, r} < lim);
  endfunction

endpackage

// File: rtl/qed_inst_decode.sv
// Combinational classifier and static (state-independent) legality check.
module qed_inst_decode
  import qed_constraint_pkg::*;
#(
  parameter int ORIG_REGS     = 16,
  parameter int MEM_ADDR_BITS = 6,
  parameter int ALLOW_SYSTEM  = 1
) (
  input  logic [31:0] instruction,
  output inst_class_t inst_class,
  output logic        static_legal
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        ld_imm_ok;
  logic        st_imm_ok;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign imm_i  = instruction[31:20];
  assign imm_s  = {instruction[31:25], instruction[11:7]};

  // Memory offsets must stay inside the small window the QED memory model covers
  assign ld_imm_ok = ((imm_i >> MEM_ADDR_BITS) == 12'd0);
  assign st_imm_ok = ((imm_s >> MEM_ADDR_BITS) == 12'd0);

  // Pick the class from the opcode and apply that class's field rules
  always_comb begin
    inst_class   = '0;
    static_legal = 1'b0;
    case (opcode)
      OP_REG: begin
        inst_class.r = 1'b1;
        static_legal = reg_ok(rd, ORIG_REGS) && reg_ok(rs1, ORIG_REGS) &&
                       reg_ok(rs2, ORIG_REGS) &&
                       ((funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR))));
      end
      OP_IMM: begin
        inst_class.i = 1'b1;
        static_legal = reg_ok(rd, ORIG_REGS) && reg_ok(rs1, ORIG_REGS);
        if (funct3 == F3_SLL) begin
          static_legal = static_legal && (funct7 == F7_BASE);
        end else if (funct3 == F3_SR) begin
          static_legal = static_legal && ((funct7 == F7_BASE) || (funct7 == F7_ALT));
        end
      end
      OP_LUI: begin
        inst_class.lui = 1'b1;
        static_legal   = reg_ok(rd, ORIG_REGS);
      end
      OP_FENCE: begin
        inst_class.fence = 1'b1;
        static_legal     = (funct3 == F3_FENCE) && reg_ok(rd, ORIG_REGS) && reg_ok(rs1, ORIG_REGS);
      end
      OP_LOAD: begin
        inst_class.ld = 1'b1;
        static_legal  = (rs1 == 5'd0) && ld_imm_ok && reg_ok(rd, ORIG_REGS) &&
                        (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OP_STORE: begin
        inst_class.st = 1'b1;
        static_legal  = (rs1 == 5'd0) && st_imm_ok && reg_ok(rs2, ORIG_REGS) &&
                        (funct3 <= 3'b010);
      end
      OP_BRANCH: begin
        inst_class.b = 1'b1;
        static_legal = reg_ok(rs1, ORIG_REGS) && reg_ok(rs2, ORIG_REGS) &&
                       (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_JAL: begin
        inst_class.jal = 1'b1;
        static_legal   = (rd == 5'd0);
      end
      OP_JALR: begin
        inst_class.jalr = 1'b1;
        static_legal    = (rd == 5'd0) && reg_ok(rs1, ORIG_REGS) && (funct3 == F3_JALR);
      end
      OP_AUIPC: begin
        inst_class.auipc = 1'b1;
        static_legal     = (rd == 5'd0);
      end
      OP_SYSTEM: begin
        inst_class.sys = 1'b1;
        static_legal   = (ALLOW_SYSTEM != 0) &&
                         ((instruction == ECALL_WORD) || (instruction == EBREAK_WORD));
      end
      OP_NOP: begin
        inst_class.nop = 1'b1;
        static_legal   = 1'b1;
      end
      default: begin
        inst_class   = '0;
        static_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/qed_inst_stream_constraint.sv
// Phase FSM (RUN -> DRAIN -> DONE), issue/gap/drain counters and sticky violation
// flag that together decide whether the presented fetch word is legal this cycle.
module qed_inst_stream_constraint
  import qed_constraint_pkg::*;
#(
  parameter int ORIG_REGS     = 16,
  parameter int MEM_ADDR_BITS = 6,
  parameter int MAX_INSTS     = 16,
  parameter int DRAIN_CYCLES  = 8,
  parameter int MIN_CTRL_GAP  = 2,
  parameter int ALLOW_CTRL    = 1,
  parameter int ALLOW_SYSTEM  = 1,
  parameter int USE_ASSUME    = 1,
  localparam int ISSUE_W      = $clog2(MAX_INSTS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic               instr_ready,
  input  logic [31:0]        instruction,
  output logic               legal,
  output logic               in_drain,
  output logic               done,
  output logic [ISSUE_W-1:0] issue_cnt,
  output logic               violation
);

  // Counter widths never drop below one bit, even for degenerate parameters
  localparam int GAP_W   = (MIN_CTRL_GAP < 1) ? 1 : $clog2(MIN_CTRL_GAP + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

  localparam logic [ISSUE_W-1:0] ISSUE_MAX  = ISSUE_W'(MAX_INSTS);
  localparam logic [ISSUE_W-1:0] ISSUE_LAST = ISSUE_W'(MAX_INSTS - 1);
  localparam logic [GAP_W-1:0]   GAP_INIT   = GAP_W'(MIN_CTRL_GAP);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  qed_phase_e         state;
  qed_phase_e         state_next;
  logic [ISSUE_W-1:0] issue_next;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_next;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DRAIN_W-1:0] drain_next;
  logic               violation_next;

  inst_class_t        inst_class;
  logic               static_legal;
  logic               class_known;
  logic               is_ctrl;
  logic               accept;

  qed_inst_decode #(
    .ORIG_REGS    (ORIG_REGS),
    .MEM_ADDR_BITS(MEM_ADDR_BITS),
    .ALLOW_SYSTEM (ALLOW_SYSTEM)
  ) u_decode (
    .instruction (instruction),
    .inst_class  (inst_class),
    .static_legal(static_legal)
  );

  assign class_known = |inst_class;
  assign is_ctrl     = inst_class.b | inst_class.jal | inst_class.jalr;
  assign accept      = instr_valid && instr_ready;
  assign in_drain    = (state == DRAIN);
  assign done        = (state == DONE);

  // Register phase, counters and violation flag; reset clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      issue_cnt <= '0;
      gap_cnt   <= '0;
      drain_cnt <= '0;
      violation <= 1'b0;
    end else begin
      state     <= state_next;
      issue_cnt <= issue_next;
      gap_cnt   <= gap_next;
      drain_cnt <= drain_next;
      violation <= violation_next;
    end
  end

  // Dynamic legality: full decode rules in RUN, NOP-only once the sequence is closed
  always_comb begin
    legal = 1'b0;
    case (state)
      RUN: begin
        legal = class_known && static_legal &&
                (!is_ctrl || ((ALLOW_CTRL != 0) && (gap_cnt == '0)));
      end
      default: begin
        legal = inst_class.nop;
      end
    endcase
  end

  // Next-state and counter updates; an illegal accept only raises the sticky flag
  always_comb begin
    state_next     = state;
    issue_next     = issue_cnt;
    gap_next       = gap_cnt;
    drain_next     = drain_cnt;
    violation_next = violation;

    if (accept && !legal) begin
      violation_next = 1'b1;
    end

    case (state)
      RUN: begin
        if (accept && legal) begin
          if (!inst_class.nop) begin
            if (issue_cnt < ISSUE_MAX) begin
              issue_next = issue_cnt + 1'b1;
            end
            if (issue_cnt == ISSUE_LAST) begin
              state_next = DRAIN;
            end
          end
          // NOPs and ordinary insts both count toward the control spacing
          if (is_ctrl) begin
            gap_next = GAP_INIT;
          end else if (gap_cnt != '0) begin
            gap_next = gap_cnt - 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = DONE;
          drain_next = '0;
        end else begin
          drain_next = drain_cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  generate
    if (USE_ASSUME != 0) begin : g_assume
      // Constrain the free fetch input so the solver only explores legal words
      assume_legal: assume property (@(posedge clk) disable iff (rst) instr_valid |-> legal);
    end
  endgenerate

endmodule

// File: tb/tb_qed_inst_stream_constraint.sv
// Directed bench: stimulus pushes expected observations, a negedge monitor checks them.
module tb_qed_inst_stream_constraint;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        legal;
  logic        in_drain;
  logic        done;
  logic [4:0]  issue_cnt;
  logic        violation;

  qed_inst_stream_constraint #(
    .USE_ASSUME(0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .legal      (legal),
    .in_drain   (in_drain),
    .done       (done),
    .issue_cnt  (issue_cnt),
    .violation  (violation)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       legal;
    logic [4:0] issue;
    logic       drain;
    logic       done;
    logic       viol;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected registered outputs as seen during the next observed cycle
  logic [4:0] m_issue;
  logic       m_drain;
  logic       m_done;
  logic       m_viol;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic chk(input string tname, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", tname, field, act, req);
    end
  endtask

  // Monitor: one queued observation per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "legal", {31'd0, legal}, {31'd0, e.legal});
      chk(e.name, "issue_cnt", {27'd0, issue_cnt}, {27'd0, e.issue});
      chk(e.name, "in_drain", {31'd0, in_drain}, {31'd0, e.drain});
      chk(e.name, "done", {31'd0, done}, {31'd0, e.done});
      chk(e.name, "violation", {31'd0, violation}, {31'd0, e.viol});
      $display("txn %-16s instr=%08h v=%b r=%b rst=%b legal=%b issue=%0d drain=%b done=%b viol=%b",
               e.name, instruction, instr_valid, instr_ready, rst, legal, issue_cnt,
               in_drain, done, violation);
    end
  end

  task automatic step(input string nm, input logic [31:0] ins, input logic v, input logic r,
                      input logic exp_legal, input logic rs);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = rs;
    instruction = ins;
    instr_valid = v;
    instr_ready = r;
    e.name  = nm;
    e.legal = exp_legal;
    e.issue = m_issue;
    e.drain = m_drain;
    e.done  = m_done;
    e.viol  = m_viol;
    sb.push_back(e);
  endtask

  logic [31:0] add_ok, add_x17, beq, bne, addi, nop, lw64, lw63, sw_bad, slli_bad;

  // Sixteen accepted ADDIs close the RUN phase
  task automatic fill16();
    for (int k = 0; k < 16; k++) begin
      step("fill_addi", addi, 1'b1, 1'b1, 1'b1, 1'b0);
      m_issue = m_issue + 5'd1;
    end
    m_drain = 1'b1;
  endtask

  initial begin
    string       tbl_name [14];
    logic [31:0] tbl_ins  [14];
    logic        tbl_legal[14];

    add_ok   = enc_r(7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1);
    add_x17  = enc_r(7'b0000000, 5'd3, 5'd2, 3'b000, 5'd17);
    beq      = enc_b(13'd8, 5'd2, 5'd1, 3'b000);
    bne      = enc_b(13'd8, 5'd2, 5'd1, 3'b001);
    addi     = enc_i(12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011);
    nop      = 32'h0000_007F;
    lw64     = enc_i(12'd64, 5'd0, 3'b010, 5'd1, 7'b0000011);
    lw63     = enc_i(12'd63, 5'd0, 3'b010, 5'd1, 7'b0000011);
    sw_bad   = enc_s(12'd0, 5'd1, 5'd2, 3'b010);
    slli_bad = enc_i({7'b0100000, 5'd1}, 5'd1, 3'b001, 5'd1, 7'b0010011);

    tbl_name[0]  = "sub";        tbl_ins[0]  = enc_r(7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1); tbl_legal[0]  = 1'b1;
    tbl_name[1]  = "sra";        tbl_ins[1]  = enc_r(7'b0100000, 5'd3, 5'd2, 3'b101, 5'd1); tbl_legal[1]  = 1'b1;
    tbl_name[2]  = "sll_alt_f7"; tbl_ins[2]  = enc_r(7'b0100000, 5'd3, 5'd2, 3'b001, 5'd1); tbl_legal[2]  = 1'b0;
    tbl_name[3]  = "srai";       tbl_ins[3]  = enc_i({7'b0100000, 5'd2}, 5'd1, 3'b101, 5'd1, 7'b0010011); tbl_legal[3] = 1'b1;
    tbl_name[4]  = "ecall";      tbl_ins[4]  = 32'h0000_0073; tbl_legal[4]  = 1'b1;
    tbl_name[5]  = "ebreak";     tbl_ins[5]  = 32'h0010_0073; tbl_legal[5]  = 1'b1;
    tbl_name[6]  = "ecall_rd1";  tbl_ins[6]  = 32'h0000_00F3; tbl_legal[6]  = 1'b0;
    tbl_name[7]  = "jal_x0";     tbl_ins[7]  = 32'h0080_006F; tbl_legal[7]  = 1'b1;
    tbl_name[8]  = "jal_x1";     tbl_ins[8]  = 32'h0080_00EF; tbl_legal[8]  = 1'b0;
    tbl_name[9]  = "auipc_x1";   tbl_ins[9]  = 32'h0000_1097; tbl_legal[9]  = 1'b0;
    tbl_name[10] = "lui_x5";     tbl_ins[10] = 32'h0000_12B7; tbl_legal[10] = 1'b1;
    tbl_name[11] = "lui_x20";    tbl_ins[11] = 32'h0000_1A37; tbl_legal[11] = 1'b0;
    tbl_name[12] = "fence";      tbl_ins[12] = 32'h0000_000F; tbl_legal[12] = 1'b1;
    tbl_name[13] = "bad_opcode"; tbl_ins[13] = 32'h0000_005B; tbl_legal[13] = 1'b0;

    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_ready = 1'b0;
    instruction = add_ok;
    m_issue = 5'd0; m_drain = 1'b0; m_done = 1'b0; m_viol = 1'b0;

    // Reset state and basic register-window check
    step("reset", add_ok, 1'b0, 1'b0, 1'b1, 1'b1);
    step("add_x1", add_ok, 1'b1, 1'b1, 1'b1, 1'b0);
    m_issue = 5'd1;
    step("add_x17", add_x17, 1'b1, 1'b0, 1'b0, 1'b0);

    // Control spacing: two accepted insts must follow a branch
    step("beq", beq, 1'b1, 1'b1, 1'b1, 1'b0);
    m_issue = 5'd2;
    step("bne_gap2", bne, 1'b1, 1'b0, 1'b0, 1'b0);
    step("addi_a", addi, 1'b1, 1'b1, 1'b1, 1'b0);
    m_issue = 5'd3;
    step("bne_gap1", bne, 1'b1, 1'b0, 1'b0, 1'b0);
    step("addi_b", addi, 1'b1, 1'b1, 1'b1, 1'b0);
    m_issue = 5'd4;
    step("bne_ok", bne, 1'b1, 1'b0, 1'b1, 1'b0);

    // Memory window rules
    step("lw_64", lw64, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lw_63", lw63, 1'b1, 1'b0, 1'b1, 1'b0);
    step("sw_rs1_x2", sw_bad, 1'b1, 1'b0, 1'b0, 1'b0);

    // Accepted illegal word: sticky flag, no count
    step("slli_bad", slli_bad, 1'b1, 1'b1, 1'b0, 1'b0);
    m_viol = 1'b1;
    step("addi_after_viol", addi, 1'b1, 1'b1, 1'b1, 1'b0);
    m_issue = 5'd5;

    for (int k = 0; k < 14; k++) begin
      step(tbl_name[k], tbl_ins[k], 1'b1, 1'b0, tbl_legal[k], 1'b0);
    end

    // Fresh sequence: fill, drain for eight cycles, then DONE
    m_issue = 5'd0; m_drain = 1'b0; m_done = 1'b0; m_viol = 1'b0;
    step("reset2", addi, 1'b0, 1'b0, 1'b1, 1'b1);
    fill16();
    step("drain_addi", addi, 1'b1, 1'b0, 1'b0, 1'b0);
    step("drain_nop", nop, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step("drain_idle", nop, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    m_drain = 1'b0;
    m_done  = 1'b1;
    step("done_addi", addi, 1'b1, 1'b0, 1'b0, 1'b0);
    step("done_nop", nop, 1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of DRAIN
    m_issue = 5'd0; m_drain = 1'b0; m_done = 1'b0; m_viol = 1'b0;
    step("reset3", addi, 1'b0, 1'b0, 1'b1, 1'b1);
    step("slli_bad2", slli_bad, 1'b1, 1'b1, 1'b0, 1'b0);
    m_viol = 1'b1;
    fill16();
    for (int k = 0; k < 3; k++) begin
      step("drain_wait", nop, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    m_issue = 5'd0; m_drain = 1'b0; m_viol = 1'b0;
    step("rst_mid_drain", nop, 1'b0, 1'b0, 1'b1, 1'b1);
    step("add_after_rst", add_ok, 1'b1, 1'b1, 1'b1, 1'b0);
    m_issue = 5'd1;
    step("after_add", nop, 1'b0, 1'b0, 1'b1, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("end", "queue_left", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
